// File: rtl/uart_core.sv
// Full-duplex 8N1 UART with a runtime baud divisor and 16x oversampling.
// Optional rx_frame_err output is enabled by defining UART_FRAME_ERR_EN.
module uart_core #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic             uart_rx,
  output logic             uart_tx,
  output logic [7:0]       rx_data,
  output logic             rx_done,
  input  logic [7:0]       tx_data,
  input  logic             tx_wr,
  output logic             tx_done
`ifdef UART_FRAME_ERR_EN
  ,
  output logic             rx_frame_err
`endif
);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BRK
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  // Shared oversample tick generator
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == '0);

  always_ff @(posedge sys_clk) begin
    if (sys_rst)          div_cnt <= '0;
    else if (tick)        div_cnt <= (divisor == '0) ? '0 : divisor - DIV_W'(1);
    else                  div_cnt <= div_cnt - DIV_W'(1);
  end

  // RX input synchronizer
  logic rx_s1, rx_s2;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
    end
  end

  // ---------------- Receiver ----------------
  rx_state_t  rx_state, rx_state_d;
  logic [3:0] rx_tcnt, rx_tcnt_d;
  logic [2:0] rx_bcnt, rx_bcnt_d;
  logic [7:0] rx_shift, rx_shift_d;
  logic [7:0] rx_data_d;
  logic       rx_done_d;
`ifdef UART_FRAME_ERR_EN
  logic       rx_err_d;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bcnt  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_state <= rx_state_d;
      rx_tcnt  <= rx_tcnt_d;
      rx_bcnt  <= rx_bcnt_d;
      rx_shift <= rx_shift_d;
      rx_data  <= rx_data_d;
      rx_done  <= rx_done_d;
    end
  end

`ifdef UART_FRAME_ERR_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) rx_frame_err <= 1'b0;
    else         rx_frame_err <= rx_err_d;
  end
`endif

  always_comb begin
    rx_state_d = rx_state;
    rx_tcnt_d  = rx_tcnt;
    rx_bcnt_d  = rx_bcnt;
    rx_shift_d = rx_shift;
    rx_data_d  = rx_data;
    rx_done_d  = 1'b0;
`ifdef UART_FRAME_ERR_EN
    rx_err_d   = 1'b0;
`endif
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s2) begin
          rx_state_d = RX_START;
          rx_tcnt_d  = '0;
        end
      end
      RX_START: begin
        // Mid start bit: a high level here was only a glitch
        if (tick) begin
          if (rx_tcnt == 4'd7) begin
            rx_tcnt_d  = '0;
            rx_bcnt_d  = '0;
            rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_tcnt_d = rx_tcnt + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          rx_tcnt_d = rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_shift_d = {rx_s2, rx_shift[7:1]};
            rx_bcnt_d  = rx_bcnt + 3'd1;
            if (rx_bcnt == 3'd7) rx_state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          rx_tcnt_d = rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            if (rx_s2) begin
              rx_data_d  = rx_shift;
              rx_done_d  = 1'b1;
              rx_state_d = RX_IDLE;
            end else begin
`ifdef UART_FRAME_ERR_EN
              rx_err_d   = 1'b1;
`endif
              rx_state_d = RX_BRK;
            end
          end
        end
      end
      RX_BRK: begin
        // Hold off until the line idles so a break is one event
        if (rx_s2) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- Transmitter ----------------
  tx_state_t  tx_state, tx_state_d;
  logic [3:0] tx_tcnt, tx_tcnt_d;
  logic [2:0] tx_bcnt, tx_bcnt_d;
  logic [7:0] tx_shift, tx_shift_d;
  logic       tx_go, tx_go_d;
  logic       uart_tx_d;
  logic       tx_done_d;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_state <= TX_IDLE;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_shift <= '0;
      tx_go    <= 1'b0;
      uart_tx  <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_state <= tx_state_d;
      tx_tcnt  <= tx_tcnt_d;
      tx_bcnt  <= tx_bcnt_d;
      tx_shift <= tx_shift_d;
      tx_go    <= tx_go_d;
      uart_tx  <= uart_tx_d;
      tx_done  <= tx_done_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state;
    tx_tcnt_d  = tx_tcnt;
    tx_bcnt_d  = tx_bcnt;
    tx_shift_d = tx_shift;
    tx_go_d    = tx_go;
    uart_tx_d  = uart_tx;
    tx_done_d  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        // The cycle tx_done is visible still counts as busy
        if (tx_wr && !tx_done) begin
          tx_shift_d = tx_data;
          tx_go_d    = 1'b0;
          tx_tcnt_d  = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        // First tick launches the start bit, 16 more end it
        if (tick) begin
          if (!tx_go) begin
            tx_go_d   = 1'b1;
            uart_tx_d = 1'b0;
            tx_tcnt_d = '0;
          end else begin
            tx_tcnt_d = tx_tcnt + 4'd1;
            if (tx_tcnt == 4'd15) begin
              uart_tx_d  = tx_shift[0];
              tx_bcnt_d  = '0;
              tx_state_d = TX_DATA;
            end
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          tx_tcnt_d = tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            if (tx_bcnt == 3'd7) begin
              uart_tx_d  = 1'b1;
              tx_state_d = TX_STOP;
            end else begin
              tx_shift_d = {1'b0, tx_shift[7:1]};
              uart_tx_d  = tx_shift[1];
              tx_bcnt_d  = tx_bcnt + 3'd1;
            end
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          tx_tcnt_d = tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            tx_done_d  = 1'b1;
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_core.sv
// Randomized self-checking bench for uart_core; expected waveforms and bytes
// come from a frame-level model of 8N1 timing (bit period = 16*divisor clocks).
module tb_uart_core;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [15:0] divisor = 16'd27;
  logic        uart_rx;
  logic        uart_tx;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_wr   = 1'b0;
  logic        tx_done;
  logic        rx_line = 1'b1;
  logic        loop_en = 1'b0;
`ifdef UART_FRAME_ERR_EN
  logic        rx_frame_err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rx_cnt  = 0, tx_cnt = 0, err_cnt = 0;
  int rx_cyc  = 0, tx_cyc = 0;
  logic [7:0] exp_rx = 8'h00;

  assign uart_rx = loop_en ? uart_tx : rx_line;

  uart_core #(.DIV_W(16)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .divisor (divisor),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .tx_data (tx_data),
    .tx_wr   (tx_wr),
    .tx_done (tx_done)
`ifdef UART_FRAME_ERR_EN
    ,
    .rx_frame_err (rx_frame_err)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Strobe monitors: count pulses and remember when they were seen
  always @(negedge sys_clk) begin
    if (rx_done === 1'b1) begin rx_cnt <= rx_cnt + 1; rx_cyc <= cyc; end
    if (tx_done === 1'b1) begin tx_cnt <= tx_cnt + 1; tx_cyc <= cyc; end
`ifdef UART_FRAME_ERR_EN
    if (rx_frame_err === 1'b1) err_cnt <= err_cnt + 1;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int eff_div();
    return (divisor == 16'd0) ? 1 : int'(divisor);
  endfunction

  // Change divisor and wait long enough for the old count to reload
  task automatic set_div(input logic [15:0] d);
    int old_eff;
    old_eff = eff_div();
    @(negedge sys_clk);
    divisor = d;
    repeat (old_eff + eff_div() + 2) @(negedge sys_clk);
  endtask

  // Send one byte and check the uart_tx waveform against the ideal frame
  task automatic tx_frame(input logic [7:0] d, input bit mid_wr);
    int bp, w, t, fall, done0, bad, low_seen;
    logic [9:0] exp_bits, got_bits;
    bp       = 16 * eff_div();
    exp_bits = {1'b1, d, 1'b0};
    got_bits = '0;
    bad      = 0;
    done0    = tx_cnt;
    @(negedge sys_clk);
    tx_data = d;
    tx_wr   = 1'b1;
    @(negedge sys_clk);
    tx_wr = 1'b0;
    w     = cyc;
    t     = 0;
    while (uart_tx !== 1'b0 && t <= eff_div() + 2) begin
      @(negedge sys_clk);
      t++;
    end
    check("tx_start_latency", 32'(uart_tx === 1'b0 && (cyc - w) >= 1 && (cyc - w) <= eff_div() + 1), 32'd1);
    if (uart_tx !== 1'b0) return;
    fall = cyc;
    for (int k = 0; k < 10 * bp; k++) begin
      if ((k % bp) >= 1 && (k % bp) <= bp - 2 && uart_tx !== exp_bits[k / bp]) bad++;
      if ((k % bp) == bp / 2) got_bits[k / bp] = uart_tx;
      if (mid_wr && k == 4 * bp + 5) begin
        tx_data = ~d;
        tx_wr   = 1'b1;
      end else begin
        tx_wr = 1'b0;
      end
      @(negedge sys_clk);
    end
    repeat (3) @(negedge sys_clk);
    check($sformatf("tx_bits_%02h", d), 32'(got_bits), 32'(exp_bits));
    check($sformatf("tx_bit_stable_%02h", d), 32'(bad), 32'd0);
    check("tx_done_count", 32'(tx_cnt - done0), 32'd1);
    check("tx_done_time", 32'((tx_cyc - fall) >= 10 * bp - 1 && (tx_cyc - fall) <= 10 * bp + 1), 32'd1);
    if (mid_wr) begin
      low_seen = 0;
      repeat (2 * eff_div() + 4) begin
        if (uart_tx !== 1'b1) low_seen++;
        @(negedge sys_clk);
      end
      check("tx_midframe_wr_ignored", 32'(low_seen), 32'd0);
    end
  endtask

  // Drive one frame on rx_line and check the receiver's verdict
  task automatic rx_frame(input logic [7:0] d, input logic stop);
    int bp, c0, cnt0, err0;
    logic [9:0] bits;
    bp   = 16 * eff_div();
    bits = {stop, d, 1'b0};
    cnt0 = rx_cnt;
    err0 = err_cnt;
    @(negedge sys_clk);
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_line = bits[i];
      repeat (bp) @(negedge sys_clk);
    end
    rx_line = 1'b1;
    repeat (4) @(negedge sys_clk);
    if (stop) begin
      exp_rx = d;
      check($sformatf("rx_done_count_%02h", d), 32'(rx_cnt - cnt0), 32'd1);
      check($sformatf("rx_data_%02h", d), 32'(rx_data), 32'(exp_rx));
      check("rx_done_time", 32'((rx_cyc - c0) >= 9 * bp && (rx_cyc - c0) <= 9 * bp + bp / 2 + 4), 32'd1);
    end else begin
      check("rx_framing_no_done", 32'(rx_cnt - cnt0), 32'd0);
      check("rx_framing_data_kept", 32'(rx_data), 32'(exp_rx));
`ifdef UART_FRAME_ERR_EN
      check("rx_frame_err_pulse", 32'(err_cnt - err0), 32'd1);
`endif
    end
  endtask

  initial begin
    int rc0, tc0, bp;
    logic [7:0] rnd;

    // Reset
    repeat (2) @(negedge sys_clk);
    check("reset_uart_tx", 32'(uart_tx), 32'd1);
    check("reset_rx_done", 32'(rx_done), 32'd0);
    check("reset_tx_done", 32'(tx_done), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    sys_rst = 1'b0;
    repeat (40) @(negedge sys_clk);

    // Directed transmit with an ignored mid-frame request
    tx_frame(8'hA5, 1'b1);

    // Directed receive
    rx_frame(8'h3C, 1'b1);
    rx_frame(8'hFF, 1'b1);

    // Short low glitch must not start a frame
    bp  = 16 * eff_div();
    rc0 = rx_cnt;
    @(negedge sys_clk);
    rx_line = 1'b0;
    repeat (100) @(negedge sys_clk);
    rx_line = 1'b1;
    repeat (bp) @(negedge sys_clk);
    check("glitch_no_done", 32'(rx_cnt - rc0), 32'd0);
    rx_frame(8'h12, 1'b1);

    // Framing error
    rx_frame(8'h81, 1'b0);
    repeat (bp) @(negedge sys_clk);
    rx_frame(8'h6D, 1'b1);

    // Loopback
    loop_en = 1'b1;
    rc0 = rx_cnt;
    tx_frame(8'h5A, 1'b0);
    repeat (bp) @(negedge sys_clk);
    exp_rx = 8'h5A;
    check("loop_rx_count", 32'(rx_cnt - rc0), 32'd1);
    check("loop_rx_data", 32'(rx_data), 32'(exp_rx));

    // Reset in the middle of a loopback frame
    @(negedge sys_clk);
    tx_data = 8'hC3;
    tx_wr   = 1'b1;
    @(negedge sys_clk);
    tx_wr = 1'b0;
    repeat (5 * bp) @(negedge sys_clk);
    rc0 = rx_cnt;
    tc0 = tx_cnt;
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("midrst_uart_tx_high", 32'(uart_tx), 32'd1);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    exp_rx  = 8'h00;
    repeat (2 * bp) @(negedge sys_clk);
    check("midrst_no_rx_done", 32'(rx_cnt - rc0), 32'd0);
    check("midrst_no_tx_done", 32'(tx_cnt - tc0), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'(exp_rx));
    rc0 = rx_cnt;
    tx_frame(8'h0F, 1'b0);
    repeat (bp) @(negedge sys_clk);
    exp_rx = 8'h0F;
    check("midrst_next_rx_count", 32'(rx_cnt - rc0), 32'd1);
    check("midrst_next_rx_data", 32'(rx_data), 32'(exp_rx));
    loop_en = 1'b0;

    // Randomized bytes at random small divisors (0 acts as 1)
    for (int n = 0; n < 6; n++) begin
      set_div(16'($urandom_range(0, 5)));
      rnd = 8'($urandom);
      tx_frame(rnd, 1'b0);
      rnd = 8'($urandom);
      rx_frame(rnd, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Full-duplex 8N1 UART transceiver (8 data bits, no parity, 1 stop bit) with a runtime baud divisor and 16x oversampling.
- Sits between board pins UART_RXD/UART_TXD and a byte-level host FSM.
- The host loads a byte and pulses tx_wr to transmit; it receives bytes through rx_data, qualified by a one-cycle rx_done strobe.

Parameters:
- DIV_W, 16: width of the divisor input and the tick counter.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- divisor  in  DIV_W  clocks per oversample tick. Equals f_clk/(baud*16); 50 MHz at 115200 baud gives 27.
- uart_rx  in  1  serial input, asynchronous, idle high.
- uart_tx  out  1  serial output, idle high.
- rx_data  out  8  last correctly framed received byte.
- rx_done  out  1  one-cycle strobe: new byte is valid on rx_data.
- tx_data  in  8  byte to send; sampled when tx_wr is accepted.
- tx_wr  in  1  transmit request strobe.
- tx_done  out  1  one-cycle strobe at the end of the stop bit.

Behaviour:
- Reset: uart_tx=1, rx_data=0, rx_done=0, tx_done=0, both FSMs idle, tick counter=0. Reset aborts any frame in progress; uart_tx returns high the cycle after sys_rst is sampled.
- Tick generator:
  - Free-running counter, shared by RX and TX.
  - Reloads to divisor-1 and emits a one-cycle tick when it reaches 0.
  - divisor=0 behaves as divisor=1 (tick every cycle).
  - A divisor change takes effect at the next reload.
  - One bit period = 16 ticks.
- RX synchronizer: two flops on uart_rx; all RX logic uses the synchronized value.
- RX FSM states: IDLE -> START -> DATA -> STOP.
  - IDLE: a synchronized low level moves to START and clears the tick count.
  - START: after 8 ticks (mid start bit), resample. If high, treat as a glitch and return to IDLE with no strobe; otherwise enter DATA.
  - DATA: sample every 16 ticks, 8 bits, LSB first, into a shift register.
  - STOP: sample 16 ticks later.
    - Stop=1: rx_data is loaded and rx_done pulses high for exactly one sys_clk, then IDLE.
    - Stop=0 (framing error): byte discarded, rx_data unchanged, no rx_done. FSM waits for uart_rx high before returning to IDLE, so a break is not seen as repeated frames.
  - rx_data holds its value between frames.
- TX FSM states: IDLE -> START -> DATA -> STOP.
  - tx_wr in IDLE: latch tx_data and go busy. Any tx_wr while busy, including the cycle tx_done is high, is ignored.
  - Each phase aligns to the next tick. uart_tx drives the start bit 0 for 16 ticks, 8 data bits LSB first for 16 ticks each, then stop bit 1 for 16 ticks.
  - On the last tick of the stop bit: tx_done pulses high for one cycle and the FSM returns to IDLE. A new tx_wr is accepted from the next cycle.
  - Latency from tx_wr to the falling edge of uart_tx is at most divisor+1 cycles.
- Simultaneous RX and TX activity is fully independent. rx_done and tx_done may assert in the same cycle.
- Outputs are registered. No combinational path from any input to any output.

Optional Feature:
- Macro UART_FRAME_ERR_EN.
- Defined: adds output rx_frame_err (1 bit, reset 0). It pulses for one cycle when the STOP sample is 0; rx_data is unchanged and rx_done stays low.
- Undefined: the port does not exist; framing errors are silently dropped as described in Behaviour.

Test Plan:
- Reset: hold sys_rst 2 cycles with uart_rx=1 -> uart_tx=1, rx_done=0, tx_done=0, rx_data=0x00.
- TX, divisor=27: tx_data=0xA5, tx_wr pulse -> uart_tx shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 432 clocks ±1. tx_done is a single pulse at the end of the stop bit. A tx_wr issued mid-frame is ignored and the frame is unchanged.
- RX, divisor=27: drive 0x3C at 432 clocks/bit -> exactly one rx_done pulse and rx_data=0x3C, within 4 cycles after the stop-bit midpoint. Then drive 0xFF -> rx_data=0xFF.
- Glitch: a low pulse of 100 clocks on idle uart_rx -> no rx_done; RX receives a following valid frame 0x12 correctly.
- Framing error: frame 0x81 with stop bit 0 -> no rx_done, rx_data keeps the prior value. With UART_FRAME_ERR_EN, rx_frame_err pulses once.
- Loopback plus mid-frame reset: wire uart_tx to uart_rx and send 0x5A -> rx_data=0x5A with both strobes seen. Asserting sys_rst mid-frame -> uart_tx=1 the next cycle, no strobes, and the next transfer 0x0F succeeds.
